// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 boot loader: FSM states and load-stream header layout.
package mips32_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  localparam logic [15:0] BOOT_MAGIC = 16'hB007;

  localparam int unsigned HDR_MAGIC_MSB = 31;
  localparam int unsigned HDR_MAGIC_LSB = 16;
  localparam int unsigned HDR_LEN_MSB   = 15;
  localparam int unsigned HDR_LEN_LSB   = 0;

endpackage

// File: rtl/mips32_boot_loader.sv
// Loads a header/data/checksum word stream into instruction memory, then
// releases the mips32 core from reset once the XOR checksum matches.
module mips32_boot_loader
  import mips32_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned RELEASE_DLY = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t      r_state;
  logic [15:0] r_len;
  logic [31:0] r_xor;
  logic [3:0]  r_dly;

  logic        w_xfer;
  logic [15:0] w_magic;
  logic [15:0] w_len;
  logic        w_hdr_bad;
  logic        w_last;

  assign w_xfer    = in_valid & in_ready;
  assign w_magic   = in_data[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
  assign w_len     = in_data[HDR_LEN_MSB:HDR_LEN_LSB];
  assign w_hdr_bad = (w_magic != BOOT_MAGIC) || (32'(w_len) > DEPTH);
  assign w_last    = (32'(words_loaded) + 32'd1) == 32'(r_len);

  // words_loaded doubles as the write index; its low ADDR_W bits address memory,
  // so reaching DEPTH never produces a wrapped write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      r_len        <= '0;
      r_xor        <= '0;
      r_dly        <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (w_xfer) begin
            words_loaded <= '0;
            r_xor        <= '0;
            r_len        <= w_len;
            if (w_hdr_bad) begin
              r_state  <= ST_ERROR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else if (w_len == 16'd0) begin
              r_state <= ST_CHECK;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            imem_we      <= 1'b1;
            imem_addr    <= words_loaded[ADDR_W-1:0];
            imem_wdata   <= in_data;
            words_loaded <= words_loaded + CNT_W'(1);
            r_xor        <= r_xor ^ in_data;
            if (w_last) r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_xfer) begin
            in_ready <= 1'b0;
            if (in_data == r_xor) begin
              r_state <= ST_RELEASE;
              r_dly   <= 4'(RELEASE_DLY);
            end else begin
              r_state <= ST_ERROR;
              error   <= 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          // Counter loaded with RELEASE_DLY; leaving on the count of one gives exactly RELEASE_DLY cycles.
          if (r_dly <= 4'd1) begin
            r_state   <= ST_RUN;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end else begin
            r_dly <= r_dly - 4'd1;
          end
        end
        ST_RUN, ST_ERROR: begin
        end
        default: begin
          r_state  <= ST_ERROR;
          in_ready <= 1'b0;
          error    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mips32_boot_loader.md
MIPS32_BOOT_LOADER -- requirements
Module: mips32_boot_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width; DEPTH = 2^ADDR_W words.
REQ-002 Parameter RELEASE_DLY, default 4, number of clock cycles between checksum pass and CPU reset release; legal range 1..15.
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  upstream load-stream word valid.
REQ-006 Port in_data  input  32  upstream load-stream word.
REQ-007 Port in_ready  output  1  loader accepts a word; transfer occurs on a cycle with in_valid and in_ready both high.
REQ-008 Port imem_we  output  1  instruction-memory write strobe, one cycle per data word.
REQ-009 Port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 Port imem_wdata  output  32  instruction-memory write data.
REQ-011 Port cpu_reset  output  1  held high to keep mips32 core in reset; low only in RUN.
REQ-012 Port done  output  1  high in RUN.
REQ-013 Port error  output  1  high in ERROR.
REQ-014 Port words_loaded  output  ADDR_W+1  count of data words written since the last header.

Function
REQ-015 Stream format SHALL be: header word, then N data words, then one checksum word. Header[31:16] = 16'hB007 and header[15:0] = N.
REQ-016 FSM states SHALL be IDLE, LOAD, CHECK, RELEASE, RUN and ERROR.
REQ-017 in_ready SHALL be 1 in IDLE, LOAD and CHECK, and 0 in RELEASE, RUN and ERROR.
REQ-018 IDLE, header accepted with magic != 16'hB007 -> ERROR.
REQ-019 IDLE, header accepted with N > DEPTH -> ERROR.
REQ-020 IDLE, valid header with N = 0 -> CHECK.
REQ-021 IDLE, valid header with 1 <= N <= DEPTH -> LOAD.
REQ-022 Header acceptance SHALL clear the word index, words_loaded and the running XOR.
REQ-023 LOAD: each accepted word SHALL produce, on the next cycle, imem_we=1, imem_addr = index[ADDR_W-1:0], imem_wdata = word.
REQ-024 LOAD: after each accepted word, index SHALL increment, words_loaded SHALL increment and the XOR SHALL accumulate the word.
REQ-025 LOAD: acceptance of the Nth word -> CHECK.
REQ-026 imem_we latency SHALL be exactly 1 cycle after acceptance; with back-to-back transfers imem_we SHALL stay high on consecutive cycles.
REQ-027 CHECK: an accepted word equal to the running XOR -> RELEASE; any other value -> ERROR.
REQ-028 RELEASE SHALL last exactly RELEASE_DLY cycles via a 4-bit down-counter, then -> RUN.
REQ-029 cpu_reset SHALL fall on the first RUN cycle.
REQ-030 RUN and ERROR SHALL be terminal until reset; in_valid in these states SHALL be ignored.
REQ-031 An in_valid drop mid-LOAD SHALL stall the FSM without a write and without an index change.
REQ-032 Index reaching DEPTH when N = DEPTH SHALL NOT wrap an address into a write; the last write goes to DEPTH-1.
REQ-033 imem_we SHALL never be asserted outside the cycle following a LOAD acceptance.

Reset
REQ-034 While reset is high: state = IDLE, in_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_reset = 1, done = 0, error = 0, words_loaded = 0; XOR, index and delay counter are cleared.
REQ-035 in_ready SHALL rise on the first clock edge after reset deassertion.
REQ-036 Reset asserted mid-LOAD SHALL abort immediately; a pending imem_we SHALL be dropped and cpu_reset SHALL stay high.

Structure
REQ-037 A shared package mips32_pkg SHALL hold the state enum, BOOT_MAGIC = 16'hB007 and the header field positions.
REQ-038 The block SHALL be a single module with no sub-modules; the XOR accumulator and the counters are inline.
REQ-039 mips32_boot_loader SHALL drive the instruction-memory write port and the reset of the existing mips32 core, which consumes cpu_reset and the loaded program.

Verification
REQ-040 Header 32'hB0070003, data 32'h20080005, 32'h2009000A, 32'h01095020, checksum equal to their XOR -> three writes to addresses 0,1,2; cpu_reset low RELEASE_DLY+1 cycles after checksum acceptance; done=1.
REQ-041 Same stream with checksum bit 0 flipped -> error=1, cpu_reset stays 1, in_ready=0, no further writes.
REQ-042 Header 32'hB0070101 with ADDR_W=8 -> ERROR after the header; zero imem_we pulses.
REQ-043 Header 32'hB0070000, then checksum 32'h0 -> RUN, words_loaded=0; a bad magic 32'hDEAD0001 instead -> ERROR.
REQ-044 in_valid toggled every other cycle during LOAD of 4 words -> exactly 4 writes at addresses 0..3 with correct data and no duplicates.
REQ-045 Reset pulse after the 2nd data word -> all outputs return to their reset values; a fresh full stream then loads from address 0 and reaches RUN.
